// File: rtl/datapath_2.sv
// ============================================================================
//  Module   : datapath_2
//  Purpose  : Single-bus 32-bit RISC datapath. Holds sixteen general
//             registers, PC, IR, MAR, MDR, Y, a 64-bit Z, a 512x32 word
//             memory and a 5-bit-opcode ALU. All of these share one 32-bit
//             bus. Every strobe comes from an external control unit, one
//             micro-step per clock.
//  Options  : DATAPATH_MULDIV_EN - when defined, opcodes 9/10 are signed
//             MUL/DIV. When undefined they load Z=0 and no multiplier or
//             divider is built.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module datapath_2 (
  input  logic        clk,
  input  logic        clr,
  // bus-source selects
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        MBIout,
  input  logic        Cout,
  input  logic        BAout,
  input  logic        Rout,
  // register load enables
  input  logic        PCin,
  input  logic        MARin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        Zin,
  input  logic        Rin,
  input  logic        CONin,
  input  logic        OutportIn,
  // IR register-field selects
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  // memory strobes
  input  logic        Read,
  input  logic        Write,
  // ALU operation and external bus source
  input  logic [4:0]  OpCode,
  input  logic [31:0] manualBusInput,
  // observable outputs
  output logic [31:0] BusMuxOut,
  output logic [31:0] OutPort,
  output logic        CON
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_AND  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_INC  = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;

  localparam int NUM_REGS  = 16;
  localparam int MEM_WORDS = 512;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] y_q, y_d;
  logic [63:0] z_q, z_d;
  logic [31:0] outport_q, outport_d;
  logic        con_q, con_d;

  logic [31:0] mem [MEM_WORDS];

  // --------------------------------------------------------------------------
  // Combinational nets
  // --------------------------------------------------------------------------
  logic [3:0]  reg_sel;
  logic [15:0] reg_dec;
  logic [31:0] c_sext;
  logic [31:0] bus;
  logic [31:0] mem_rdata;
  logic [4:0]  shamt;
  logic [63:0] rot_r;
  logic [63:0] rot_l;
  logic [63:0] mul_res;
  logic [63:0] div_res;
  logic [63:0] alu_res;
  logic        cond;
  logic        unused_bits;

  // The three field selects are OR-ed so the control unit may assert several
  // at once. Normally only one is high.
  assign reg_sel = ({4{Gra}} & ir_q[26:23])
                 | ({4{Grb}} & ir_q[22:19])
                 | ({4{Grc}} & ir_q[18:15]);

  // One-hot decode of the selected register number
  always_comb begin
    reg_dec          = 16'd0;
    reg_dec[reg_sel] = 1'b1;
  end

  // Immediate field of the IR, sign-extended from bit 18
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};

  // Memory read is asynchronous from the low MAR bits
  assign mem_rdata = mem[mar_q[8:0]];

  // Bus source priority: MBI > Zlow > MDR > PC > C > register
  always_comb begin
    bus = 32'd0;
    if (MBIout) begin
      bus = manualBusInput;
    end else if (Zlowout) begin
      bus = z_q[31:0];
    end else if (MDRout) begin
      bus = mdr_q;
    end else if (PCout) begin
      bus = pc_q;
    end else if (Cout) begin
      bus = c_sext;
    end else if (Rout || BAout) begin
      // Base-address use of R0 reads as the constant zero
      bus = (BAout && (reg_sel == 4'd0)) ? 32'd0 : regs_q[reg_sel];
    end
  end

  assign BusMuxOut = bus;

  // --------------------------------------------------------------------------
  // ALU: A is Y, B is the bus
  // --------------------------------------------------------------------------
  assign shamt = bus[4:0];
  // Rotates come from a doubled copy of A so that a zero amount needs no
  // special case.
  assign rot_r = {y_q, y_q} >> shamt;
  assign rot_l = {y_q, y_q} << shamt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] mul_full;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  assign mul_full = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
  assign mul_res  = mul_full;

  // Signed divide built from an unsigned divide on magnitudes. This form
  // also wraps cleanly for -2^31 / -1. The remainder takes the dividend's
  // sign.
  always_comb begin
    a_mag = y_q[31] ? (32'd0 - y_q) : y_q;
    b_mag = bus[31] ? (32'd0 - bus) : bus;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo     = (y_q[31] ^ bus[31]) ? (32'd0 - q_mag) : q_mag;
    rem     = y_q[31] ? (32'd0 - r_mag) : r_mag;
    div_res = (bus == 32'd0) ? 64'd0 : {rem, quo};
  end
`else
  assign mul_res = 64'd0;
  assign div_res = 64'd0;
`endif

  // Opcode decode. 32-bit results are zero-extended into Z.
  always_comb begin
    alu_res = {32'd0, bus};
    case (OpCode)
      OP_ADD:  alu_res = {32'd0, y_q + bus};
      OP_AND:  alu_res = {32'd0, y_q & bus};
      OP_OR:   alu_res = {32'd0, y_q | bus};
      OP_SUB:  alu_res = {32'd0, y_q - bus};
      OP_SHR:  alu_res = {32'd0, y_q >> shamt};
      OP_SHRA: alu_res = {32'd0, $signed(y_q) >>> shamt};
      OP_SHL:  alu_res = {32'd0, y_q << shamt};
      OP_ROR:  alu_res = {32'd0, rot_r[31:0]};
      OP_ROL:  alu_res = {32'd0, rot_l[63:32]};
      OP_MUL:  alu_res = mul_res;
      OP_DIV:  alu_res = div_res;
      OP_NEG:  alu_res = {32'd0, 32'd0 - bus};
      OP_INC:  alu_res = {32'd0, bus + 32'd1};
      OP_NOT:  alu_res = {32'd0, ~bus};
      default: alu_res = {32'd0, bus};
    endcase
  end

  // Branch condition on the bus value, chosen by IR[20:19]
  always_comb begin
    case (ir_q[20:19])
      2'b00:   cond = (bus == 32'd0);
      2'b01:   cond = (bus != 32'd0);
      2'b10:   cond = ~bus[31];
      default: cond = bus[31];
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Each register holds unless its load enable is high
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = (Rin && reg_dec[i]) ? bus : regs_q[i];
    end
    pc_d      = PCin      ? bus : pc_q;
    ir_d      = IRin      ? bus : ir_q;
    mar_d     = MARin     ? bus : mar_q;
    y_d       = Yin       ? bus : y_q;
    outport_d = OutportIn ? bus : outport_q;
    z_d       = Zin       ? alu_res : z_q;
    con_d     = CONin     ? cond : con_q;
    mdr_d     = mdr_q;
    if (MDRin) begin
      mdr_d = Read ? mem_rdata : bus;
    end
  end

  // Register file and special registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
      end
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      mar_q     <= 32'd0;
      mdr_q     <= 32'd0;
      y_q       <= 32'd0;
      z_q       <= 64'd0;
      outport_q <= 32'd0;
      con_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      z_q       <= z_d;
      outport_q <= outport_d;
      con_q     <= con_d;
    end
  end

  // Memory write stores the pre-edge MDR, so Write+MDRin stores the old value.
  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (Write) begin
      mem[mar_q[8:0]] <= mdr_q;
    end
  end

  assign OutPort = outport_q;
  assign CON     = con_q;

  // Bits with no consumer inside the datapath: the opcode field, the upper
  // MAR bits and the upper half of Z.
  assign unused_bits = ^{ir_q[31:27], mar_q[31:9], z_q[63:32]};

endmodule

`default_nettype wire

// File: tb/tb_datapath_2.sv
// ============================================================================
//  Module   : tb_datapath_2
//  Purpose  : Self-checking bench for datapath_2. It keeps a behavioural
//             model of the architectural state and checks the bus, OutPort,
//             CON and Z against it every cycle. Directed sequences use
//             literal expectations. A randomized micro-step stream follows.
//  Options  : DATAPATH_MULDIV_EN (must match the RTL build)
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_datapath_2;

  logic        clk;
  logic        clr;
  logic        PCout, Zlowout, MDRout, MBIout, Cout, BAout, Rout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn;
  logic        Gra, Grb, Grc;
  logic        Read, Write;
  logic [4:0]  OpCode;
  logic [31:0] manualBusInput;
  logic [31:0] BusMuxOut;
  logic [31:0] OutPort;
  logic        CON;

  datapath_2 dut (
    .clk(clk), .clr(clr),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MBIout(MBIout),
    .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zin(Zin), .Rin(Rin), .CONin(CONin), .OutportIn(OutportIn),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Read(Read), .Write(Write),
    .OpCode(OpCode), .manualBusInput(manualBusInput),
    .BusMuxOut(BusMuxOut), .OutPort(OutPort), .CON(CON)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the architectural state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_out;
  logic [63:0] m_z;
  logic        m_con;
  logic [31:0] m_mem [512];
  logic        m_wr  [512];
  logic [31:0] exp_bus;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_ctrl();
    {PCout, Zlowout, MDRout, MBIout, Cout, BAout, Rout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn} = '0;
    {Gra, Grb, Grc, Read, Write} = '0;
    OpCode = 5'd0;
    manualBusInput = 32'd0;
  endtask

  function automatic int sel_idx();
    int s = 0;
    if (Gra) s = s | int'(m_ir[26:23]);
    if (Grb) s = s | int'(m_ir[22:19]);
    if (Grc) s = s | int'(m_ir[18:15]);
    return s;
  endfunction

  function automatic logic [31:0] model_bus();
    int s, c;
    s = sel_idx();
    if (MBIout)  return manualBusInput;
    if (Zlowout) return m_z[31:0];
    if (MDRout)  return m_mdr;
    if (PCout)   return m_pc;
    if (Cout) begin
      c = int'(m_ir[18:0]);
      if (m_ir[18]) c = c - (1 << 19);
      return c;
    end
    if (Rout || BAout) return (BAout && s == 0) ? 32'd0 : m_r[s];
    return 32'd0;
  endfunction

  function automatic logic [63:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
    int unsigned n;
    int sa, sb;
    longint p, q, rm;
    logic [31:0] r;
    n  = b[4:0];
    sa = a;
    sb = b;
    p  = 0;
    q  = 0;
    rm = 0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a & b;
      5'd2:  r = a | b;
      5'd3:  r = a - b;
      5'd4:  r = a >> n;
      5'd5:  r = sa >>> n;
      5'd6:  r = a << n;
      5'd7:  r = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      5'd8:  r = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      5'd9: begin
`ifdef DATAPATH_MULDIV_EN
        p = longint'(sa) * longint'(sb);
`endif
        return p;
      end
      5'd10: begin
`ifdef DATAPATH_MULDIV_EN
        if (b == 32'd0) return 64'd0;
        q  = longint'(sa) / longint'(sb);
        rm = longint'(sa) % longint'(sb);
        return {rm[31:0], q[31:0]};
`else
        return 64'd0;
`endif
      end
      5'd11: r = 32'd0 - b;
      5'd12: r = b + 32'd1;
      5'd13: r = ~b;
      default: r = b;
    endcase
    return {32'd0, r};
  endfunction

  function automatic logic model_con(input logic [31:0] b);
    int sb = b;
    case (m_ir[20:19])
      2'b00:   return b == 32'd0;
      2'b01:   return b != 32'd0;
      2'b10:   return sb >= 0;
      default: return sb < 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_out = 0;
    m_z = 0; m_con = 0;
  endtask

  // One micro-step: controls are already driven. The model advances at the
  // rising edge.
  task automatic step();
    logic [31:0] b, n_pc, n_ir, n_mar, n_mdr, n_y, n_out, wd;
    logic [63:0] n_z;
    logic        n_con, do_w, do_r;
    logic [8:0]  wa;
    int          s;
    s       = sel_idx();
    b       = model_bus();
    exp_bus = b;
    n_pc  = PCin      ? b : m_pc;
    n_ir  = IRin      ? b : m_ir;
    n_mar = MARin     ? b : m_mar;
    n_y   = Yin       ? b : m_y;
    n_out = OutportIn ? b : m_out;
    n_mdr = MDRin ? (Read ? m_mem[m_mar[8:0]] : b) : m_mdr;
    n_z   = Zin   ? model_alu(m_y, b, OpCode) : m_z;
    n_con = CONin ? model_con(b) : m_con;
    do_r  = Rin;
    do_w  = Write;
    wa    = m_mar[8:0];
    wd    = m_mdr;
    @(negedge clk);
    @(posedge clk);
    m_pc = n_pc; m_ir = n_ir; m_mar = n_mar; m_y = n_y; m_out = n_out;
    m_mdr = n_mdr; m_z = n_z; m_con = n_con;
    if (do_r) m_r[s] = b;
    if (do_w) begin
      m_mem[wa] = wd;
      m_wr[wa]  = 1'b1;
    end
    #1;
  endtask

  // Check the bus with the sources the caller has set, then spend one cycle
  task automatic peek(input string name, input logic [31:0] exp);
    #1;
    chk(name, BusMuxOut, exp);
    step();
  endtask

  // Asynchronous reset pulse, with an external bus source held during it
  task automatic do_reset();
    logic [31:0] v;
    clear_ctrl();
    v = $urandom;
    MBIout = 1'b1;
    manualBusInput = v;
    clr = 1'b0;
    model_reset();
    exp_bus = model_bus();
    #1;
    chk("bus_during_reset", BusMuxOut, v);
    @(negedge clk);
    @(posedge clk);
    #1;
    clr = 1'b1;
    clear_ctrl();
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus", BusMuxOut, exp_bus);
      chk("outport", OutPort, m_out);
      chk("con", CON, m_con);
      chk("z", dut.z_q, m_z);
    end
  end

  initial begin
    clr = 1'b1;
    clear_ctrl();
    for (int i = 0; i < 512; i++) begin
      m_mem[i] = 32'd0;
      m_wr[i]  = 1'b0;
    end
    model_reset();
    exp_bus = 32'd0;
    #1;
    chk_en = 1'b1;

    // Reset state
    do_reset();
    chk("reset_outport", OutPort, 32'd0);
    chk("reset_con", CON, 1'b0);
    clear_ctrl(); PCout = 1; peek("reset_pc", 32'd0);

    // PC increment
    clear_ctrl(); MBIout = 1; manualBusInput = 32'd0; PCin = 1; MARin = 1; step();
    clear_ctrl(); PCout = 1; Zin = 1; OpCode = 5'd12; step();
    clear_ctrl(); Zlowout = 1; PCin = 1; step();
    clear_ctrl(); PCout = 1; peek("pc_inc", 32'd1);
    chk("mar_zero", dut.mar_q, 32'd0);

    // andi R2, R3, 37
    clear_ctrl(); MBIout = 1; manualBusInput = 32'h6918_0025; IRin = 1; step();
    clear_ctrl(); MBIout = 1; manualBusInput = 32'd2; Grb = 1; Rin = 1; step();
    clear_ctrl(); Grb = 1; Rout = 1; peek("r3_val", 32'd2);
    clear_ctrl(); Grb = 1; Rout = 1; Yin = 1; step();
    clear_ctrl(); Cout = 1; OpCode = 5'd1; Zin = 1; step();
    clear_ctrl(); Zlowout = 1; Gra = 1; Rin = 1; step();
    clear_ctrl(); Gra = 1; Rout = 1; peek("andi_r2", 32'd0);
    clear_ctrl(); Cout = 1; peek("cout_imm", 32'h0000_0025);

    // Memory round trip
    clear_ctrl(); MBIout = 1; manualBusInput = 32'hDEAD_BEEF; MDRin = 1; step();
    clear_ctrl(); MBIout = 1; manualBusInput = 32'd5; MARin = 1; step();
    clear_ctrl(); Write = 1; step();
    clear_ctrl(); MBIout = 1; manualBusInput = 32'd0; MDRin = 1; step();
    clear_ctrl(); MDRout = 1; peek("mdr_cleared", 32'd0);
    clear_ctrl(); Read = 1; MDRin = 1; step();
    clear_ctrl(); MDRout = 1; peek("mem_roundtrip", 32'hDEAD_BEEF);

    // BAout on R0 and CON with the "nonzero" condition
    clear_ctrl(); MBIout = 1; manualBusInput = 32'h0008_0000; IRin = 1; step();
    clear_ctrl(); MBIout = 1; manualBusInput = 32'h55; Gra = 1; Rin = 1; step();
    clear_ctrl(); Gra = 1; Rout = 1; peek("r0_rout", 32'h55);
    clear_ctrl(); Gra = 1; BAout = 1; peek("r0_baout", 32'd0);
    clear_ctrl(); MBIout = 1; manualBusInput = 32'd7; CONin = 1; step();
    chk("con_nonzero", CON, 1'b1);

    // Output port
    clear_ctrl(); MBIout = 1; manualBusInput = 32'h1234_5678; OutportIn = 1; step();
    chk("outport_load", OutPort, 32'h1234_5678);

    // Signed multiply (-3 * 4)
    clear_ctrl(); MBIout = 1; manualBusInput = 32'hFFFF_FFFD; Yin = 1; step();
    clear_ctrl(); MBIout = 1; manualBusInput = 32'd4; OpCode = 5'd9; Zin = 1; step();
`ifdef DATAPATH_MULDIV_EN
    chk("mul_z", dut.z_q, 64'hFFFF_FFFF_FFFF_FFF4);
`else
    chk("mul_z", dut.z_q, 64'd0);
`endif

    // Randomized micro-step stream
    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) do_reset();
      clear_ctrl();
      manualBusInput = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      MBIout  = ($urandom_range(0, 3) == 0);
      Zlowout = ($urandom_range(0, 4) == 0);
      MDRout  = ($urandom_range(0, 4) == 0);
      PCout   = ($urandom_range(0, 4) == 0);
      Cout    = ($urandom_range(0, 4) == 0);
      BAout   = ($urandom_range(0, 4) == 0);
      Rout    = ($urandom_range(0, 2) == 0);
      PCin    = ($urandom_range(0, 3) == 0);
      MARin   = ($urandom_range(0, 3) == 0);
      MDRin   = ($urandom_range(0, 3) == 0);
      IRin    = ($urandom_range(0, 5) == 0);
      Yin     = ($urandom_range(0, 2) == 0);
      Zin     = ($urandom_range(0, 1) == 0);
      Rin     = ($urandom_range(0, 2) == 0);
      CONin   = ($urandom_range(0, 2) == 0);
      OutportIn = ($urandom_range(0, 3) == 0);
      Gra     = ($urandom_range(0, 1) == 0);
      Grb     = ($urandom_range(0, 2) == 0);
      Grc     = ($urandom_range(0, 3) == 0);
      Read    = ($urandom_range(0, 2) == 0);
      Write   = ($urandom_range(0, 3) == 0);
      OpCode  = 5'($urandom_range(0, 31));
      if (Read && MDRin && !m_wr[m_mar[8:0]]) Read = 1'b0;
      step();
    end

    clear_ctrl();
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/datapath_2.md
# datapath_2

Single-bus 32-bit RISC datapath: sixteen general registers, PC, IR, MAR, MDR, Y, 64-bit Z, a 512×32 word memory and a 5-bit-opcode ALU, all sharing one 32-bit bus. It holds no instruction sequencer. Every control strobe comes from an external control unit or bench, one micro-step per clock. It sits between the control unit and the memory/IO layer of the CPU.

## Interface
- No parameters.
- clk  in  1  rising-edge clock for all state.
- clr  in  1  asynchronous, active-low reset.
- PCout, Zlowout, MDRout, MBIout, Cout, BAout, Rout  in  1 each  bus-source selects.
- PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin, OutportIn  in  1 each  register load enables.
- Gra, Grb, Grc  in  1 each  select IR register field.
- Read, Write  in  1 each  memory read / write strobes.
- OpCode  in  5  ALU operation.
- manualBusInput  in  32  external bus source, driven when MBIout=1.
- BusMuxOut  out  32  current bus value.
- OutPort  out  32  output-port register.
- CON  out  1  branch-condition flip-flop.

## Operation
- **Bus mux**
  - Priority when several sources are asserted: MBIout > Zlowout > MDRout > PCout > Cout > register (Rout or BAout).
  - With no source asserted the bus is 0.
- **Cout** drives the sign-extended IR[18:0] onto the bus.
- **Select/encode**
  - Field select: Gra→IR[26:23], Grb→IR[22:19], Grc→IR[18:15].
  - The Gr* signals are OR-ed, and the result is decoded to R0–R15.
  - The addressed register loads from the bus when Rin=1.
  - It drives the bus when Rout=1 or BAout=1.
  - BAout with R0 selected drives 0.
- **MDR**: on MDRin, loads memory[MAR[8:0]] if Read=1, otherwise loads the bus.
- **Memory**: Write=1 stores MDR into memory[MAR[8:0]].
- **MAR, PC, IR, Y, OutPort**: each loads the bus when its enable is high.
- **Z**: loads the 64-bit ALU result on Zin. A = Y, B = bus.
- **ALU opcodes** (result is zero-extended to 64 bits unless noted):
  - 0 ADD; 1 AND; 2 OR; 3 SUB (A−B)
  - 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL: shift/rotate A by B[4:0]
  - 9 MUL (signed, 64-bit); 10 DIV (Z[31:0]=quotient, Z[63:32]=remainder)
  - 11 NEG B; 12 INC (B+1); 13 NOT B; 14–31 pass B
  - All 32-bit arithmetic wraps mod 2^32.
  - DIV with B=0 yields Z=0.
- **CON**: on CONin, latches a condition on the bus value selected by IR[20:19]:
  - 00: bus==0
  - 01: bus!=0
  - 10: bus[31]==0
  - 11: bus[31]==1

## Timing
- All registers and memory writes update on the rising clk edge while their enable is high.
- Strobes must be held across a rising edge to take effect.
- The bus and ALU are combinational, so a source and a destination may be asserted in the same cycle.
- Memory read is combinational from MAR. Read+MDRin captures the data in one cycle.
- Write and MDRin in the same cycle store the old MDR and then load the new one.
- clr=0 immediately clears R0–R15, PC, IR, MAR, MDR, Y, Z, OutPort and CON. Memory is not cleared.
- While reset is held, BusMuxOut still reflects the asserted source. Reset mid-sequence discards all state.

## Configuration
- DATAPATH_MULDIV_EN defined: opcodes 9 and 10 implement MUL and DIV as above.
- DATAPATH_MULDIV_EN undefined: opcodes 9 and 10 load Z=0, and no multiplier or divider is synthesized.

## Test plan
- Reset: clr=0 pulse → OutPort=0, CON=0, and reading PC via PCout shows 0.
- PC increment: MBIout with 0 plus PCin,MARin; then PCout,Zin,OpCode=12; then Zlowout,PCin → PC=1, MAR=0.
- andi sequence:
  - Load IR=0x69180025 via MBIout/IRin, then manualBusInput=2 with Grb,Rin → R3=2.
  - Grb,Rout,Yin; then Cout,OpCode=1,Zin; then Zlowout,Gra,Rin → R2=0 (2 & 37).
  - Cout alone drives bus 0x00000025.
- Memory round trip:
  - Write 0xDEADBEEF to MDR, MAR=5, assert Write.
  - Clear MDR, then Read+MDRin → MDR=0xDEADBEEF.
- BAout with IR ra=R0 drives bus 0. CONin with IR[20:19]=01 and bus 7 → CON=1.
- With DATAPATH_MULDIV_EN, Y=−3 and bus 4 with OpCode 9 → Z=0xFFFFFFFF_FFFFFFF4. Without it → Z=0.
